constraint_stream_eval: RTL and testbench



---
 rtl/constraint_stream_eval_pkg.sv | 17 +
 rtl/constraint_stream_eval_channel.sv | 35 +++
 rtl/constraint_stream_eval.sv | 103 ++++++++++
 tb/tb_constraint_stream_eval.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/constraint_stream_eval_pkg.sv
// Shared types and helpers for the constraint stream evaluator.
// Optional per-channel combine selection is enabled by CSE_OP_SEL_EN.
package cse_pkg;

  typedef enum logic {ACCUM, REPORT} state_t;

  localparam logic [1:0] CSE_OP_OR  = 2'b00;
  localparam logic [1:0] CSE_OP_AND = 2'b01;
  localparam logic [1:0] CSE_OP_XOR = 2'b10;
  localparam logic [1:0] CSE_OP_ADD = 2'b11;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/constraint_stream_eval_channel.sv
// One constraint lane: viol is set when combine(a, b) equals k modulo 2^WIDTH.
// With CSE_OP_SEL_EN the combine is selected by op, otherwise it is OR.
module cse_channel
  import cse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] k,
`ifdef CSE_OP_SEL_EN
  input  logic [1:0]       op,
`endif
  output logic             viol
);

  logic [WIDTH-1:0] comb;
  logic [WIDTH-1:0] diff;

  always_comb begin
`ifdef CSE_OP_SEL_EN
    case (op)
      CSE_OP_AND: comb = a & b;
      CSE_OP_XOR: comb = a ^ b;
      CSE_OP_ADD: comb = a + b;
      default:    comb = a | b;
    endcase
`else
    comb = a | b;
`endif
    diff = comb - k;
    viol = ~|diff;
  end

endmodule

// File: rtl/constraint_stream_eval.sv
// Streaming multi-channel constraint checker: accumulates per-frame violations
// and emits one verdict per frame. Optional op select via CSE_OP_SEL_EN.
module constraint_stream_eval
  import cse_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_a,
  input  logic [NUM_CH*WIDTH-1:0] in_b,
  input  logic                    in_last,
  input  logic [NUM_CH*WIDTH-1:0] cfg_k,
`ifdef CSE_OP_SEL_EN
  input  logic [2*NUM_CH-1:0]     cfg_op,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_pass,
  output logic [NUM_CH-1:0]       out_fail_mask,
  output logic [CNT_W-1:0]        out_fail_cnt,
  output logic [CNT_W-1:0]        out_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] viol;
  logic [NUM_CH-1:0] acc_mask, mask_nxt;
  logic [CNT_W-1:0]  acc_fail, fail_nxt;
  logic [CNT_W-1:0]  acc_beats, beats_nxt;
  logic              accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cse_channel #(.WIDTH(WIDTH)) u_ch (
      .a    (in_a[c*WIDTH +: WIDTH]),
      .b    (in_b[c*WIDTH +: WIDTH]),
      .k    (cfg_k[c*WIDTH +: WIDTH]),
`ifdef CSE_OP_SEL_EN
      .op   (cfg_op[2*c +: 2]),
`endif
      .viol (viol[c])
    );
  end

  assign accept    = in_valid & in_ready;
  assign mask_nxt  = acc_mask | viol;
  assign fail_nxt  = (|viol) ? CNT_W'(sat_add(32'(acc_fail), 32'(CNT_MAX))) : acc_fail;
  assign beats_nxt = CNT_W'(sat_add(32'(acc_beats), 32'(CNT_MAX)));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc_mask      <= '0;
      acc_fail      <= '0;
      acc_beats     <= '0;
      out_pass      <= 1'b0;
      out_fail_mask <= '0;
      out_fail_cnt  <= '0;
      out_beats     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (in_last) begin
          // Verdict includes the closing beat; accumulators restart for the next frame.
          out_pass      <= (mask_nxt == '0);
          out_fail_mask <= mask_nxt;
          out_fail_cnt  <= fail_nxt;
          out_beats     <= beats_nxt;
          acc_mask      <= '0;
          acc_fail      <= '0;
          acc_beats     <= '0;
        end else begin
          acc_mask  <= mask_nxt;
          acc_fail  <= fail_nxt;
          acc_beats <= beats_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_constraint_stream_eval.sv
// Directed bench for constraint_stream_eval; a second instance with CNT_W=4
// shares the stimulus to exercise counter saturation.
module tb_constraint_stream_eval;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a, in_b, cfg_k;
  logic        in_last;
  logic        out_ready;
`ifdef CSE_OP_SEL_EN
  logic [7:0]  cfg_op;
`endif

  logic        in_ready, out_valid, out_pass;
  logic [3:0]  out_fail_mask;
  logic [15:0] out_fail_cnt, out_beats;

  logic        s_in_ready, s_out_valid, s_out_pass;
  logic [3:0]  s_fail_mask;
  logic [3:0]  s_fail_cnt, s_beats;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  constraint_stream_eval #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .cfg_k(cfg_k),
`ifdef CSE_OP_SEL_EN
    .cfg_op(cfg_op),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pass(out_pass),
    .out_fail_mask(out_fail_mask), .out_fail_cnt(out_fail_cnt), .out_beats(out_beats)
  );

  constraint_stream_eval #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .cfg_k(cfg_k),
`ifdef CSE_OP_SEL_EN
    .cfg_op(cfg_op),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pass(s_out_pass),
    .out_fail_mask(s_fail_mask), .out_fail_cnt(s_fail_cnt), .out_beats(s_beats)
  );

  function automatic logic [31:0] rep(input logic [7:0] v);
    return {4{v}};
  endfunction

  // Present one beat at a negedge and return right after the edge that takes it.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int wait_cyc;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic ack_verdict();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks += 6;
    if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    if (out_pass !== 1'b0)    begin n_fail++; $display("FAIL reset_pass: got %0b want 0", out_pass); end
    if (out_fail_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", out_fail_mask); end
    if (out_fail_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fail_cnt: got %0d want 0", out_fail_cnt); end
    if (out_beats !== 16'd0)  begin n_fail++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
  endtask

  task automatic test_all_pass();
    cfg_k = rep(8'h70);
    send_beat(rep(8'h10), rep(8'h01), 1'b0);
    send_beat(rep(8'h10), rep(8'h01), 1'b0);
    send_beat(rep(8'h10), rep(8'h01), 1'b1);
    @(negedge clk);
    n_checks += 6;
    if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL pass_latency: out_valid=%0b want 1", out_valid); end
    if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL pass_ready: in_ready=%0b want 0", in_ready); end
    if (out_pass !== 1'b1)      begin n_fail++; $display("FAIL pass_pass: got %0b want 1", out_pass); end
    if (out_fail_mask !== 4'h0) begin n_fail++; $display("FAIL pass_mask: got %h want 0", out_fail_mask); end
    if (out_fail_cnt !== 16'd0) begin n_fail++; $display("FAIL pass_fail_cnt: got %0d want 0", out_fail_cnt); end
    if (out_beats !== 16'd3)    begin n_fail++; $display("FAIL pass_beats: got %0d want 3", out_beats); end
    ack_verdict();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drop: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_exact_hit();
    cfg_k = rep(8'h70);
    send_beat(rep(8'h01), rep(8'h02), 1'b0);
    send_beat(32'h01600101, 32'h02100202, 1'b0);
    send_beat(rep(8'h01), rep(8'h02), 1'b0);
    send_beat(rep(8'h01), rep(8'h02), 1'b1);
    @(negedge clk);
    n_checks += 5;
    if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL hit_valid: got %0b want 1", out_valid); end
    if (out_pass !== 1'b0)      begin n_fail++; $display("FAIL hit_pass: got %0b want 0", out_pass); end
    if (out_fail_mask !== 4'b0100) begin n_fail++; $display("FAIL hit_mask: got %b want 0100", out_fail_mask); end
    if (out_fail_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_fail_cnt: got %0d want 1", out_fail_cnt); end
    if (out_beats !== 16'd4)    begin n_fail++; $display("FAIL hit_beats: got %0d want 4", out_beats); end
    ack_verdict();
  endtask

  task automatic test_back_pressure();
    cfg_k = rep(8'h70);
    send_beat(rep(8'h70), rep(8'h00), 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_a = rep(8'h01); in_b = rep(8'h00); in_last = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks += 5;
      if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
      if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, in_ready); end
      if (out_fail_mask !== 4'hf) begin n_fail++; $display("FAIL bp_mask[%0d]: got %h want f", i, out_fail_mask); end
      if (out_beats !== 16'd1)    begin n_fail++; $display("FAIL bp_beats[%0d]: got %0d want 1", i, out_beats); end
      if (out_pass !== 1'b0)      begin n_fail++; $display("FAIL bp_pass[%0d]: got %0b want 0", i, out_pass); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks += 4;
    if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL bp_after_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL bp_after_ready: got %0b want 1", in_ready); end
    if (out_fail_mask !== 4'hf) begin n_fail++; $display("FAIL bp_hold_mask: got %h want f", out_fail_mask); end
    if (out_beats !== 16'd1)    begin n_fail++; $display("FAIL bp_hold_beats: got %0d want 1", out_beats); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks += 3;
    if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_next_valid: got %0b want 1", out_valid); end
    if (out_fail_mask !== 4'h0) begin n_fail++; $display("FAIL bp_next_mask: got %h want 0", out_fail_mask); end
    if (out_pass !== 1'b1)      begin n_fail++; $display("FAIL bp_next_pass: got %0b want 1", out_pass); end
    ack_verdict();
  endtask

  task automatic test_saturation();
    cfg_k = rep(8'h70);
    for (int i = 0; i < 20; i++) send_beat(rep(8'h70), rep(8'h00), (i == 19));
    @(negedge clk);
    n_checks += 6;
    if (s_out_valid !== 1'b1)   begin n_fail++; $display("FAIL sat_valid: got %0b want 1", s_out_valid); end
    if (s_fail_cnt !== 4'd15)   begin n_fail++; $display("FAIL sat_fail_cnt: got %0d want 15", s_fail_cnt); end
    if (s_beats !== 4'd15)      begin n_fail++; $display("FAIL sat_beats: got %0d want 15", s_beats); end
    if (s_fail_mask !== 4'hf)   begin n_fail++; $display("FAIL sat_mask: got %h want f", s_fail_mask); end
    if (out_fail_cnt !== 16'd20) begin n_fail++; $display("FAIL wide_fail_cnt: got %0d want 20", out_fail_cnt); end
    if (out_beats !== 16'd20)   begin n_fail++; $display("FAIL wide_beats: got %0d want 20", out_beats); end
    ack_verdict();
  endtask

  task automatic test_reset_mid_frame();
    cfg_k = rep(8'h70);
    send_beat(rep(8'h70), rep(8'h00), 1'b0);
    send_beat(rep(8'h70), rep(8'h00), 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    if (out_beats !== 16'd0) begin n_fail++; $display("FAIL rstmid_beats: got %0d want 0", out_beats); end
    send_beat(rep(8'h10), rep(8'h01), 1'b1);
    @(negedge clk);
    n_checks += 4;
    if (out_beats !== 16'd1)    begin n_fail++; $display("FAIL rstmid_frame_beats: got %0d want 1", out_beats); end
    if (out_fail_mask !== 4'h0) begin n_fail++; $display("FAIL rstmid_frame_mask: got %h want 0", out_fail_mask); end
    if (out_fail_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_fail_cnt: got %0d want 0", out_fail_cnt); end
    if (out_pass !== 1'b1)      begin n_fail++; $display("FAIL rstmid_frame_pass: got %0b want 1", out_pass); end
    ack_verdict();
  endtask

`ifdef CSE_OP_SEL_EN
  task automatic test_op_sel();
    cfg_k = rep(8'h70);
    cfg_op = 8'b00_00_00_11;
    send_beat(rep(8'h38), rep(8'h38), 1'b1);
    @(negedge clk);
    n_checks += 2;
    if (out_fail_mask !== 4'b0001) begin n_fail++; $display("FAIL op_add_mask: got %b want 0001", out_fail_mask); end
    if (out_pass !== 1'b0)         begin n_fail++; $display("FAIL op_add_pass: got %0b want 0", out_pass); end
    ack_verdict();
    cfg_op = 8'b00_00_00_10;
    send_beat(rep(8'h38), rep(8'h38), 1'b1);
    @(negedge clk);
    n_checks += 2;
    if (out_fail_mask !== 4'b0000) begin n_fail++; $display("FAIL op_xor_mask: got %b want 0000", out_fail_mask); end
    if (out_pass !== 1'b1)         begin n_fail++; $display("FAIL op_xor_pass: got %0b want 1", out_pass); end
    ack_verdict();
    cfg_op = 8'h00;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    cfg_k = '0; out_ready = 1'b0;
`ifdef CSE_OP_SEL_EN
    cfg_op = 8'h00;
`endif
    test_reset();
    test_all_pass();
    test_exact_hit();
    test_back_pressure();
    test_saturation();
    test_reset_mid_frame();
`ifdef CSE_OP_SEL_EN
    test_op_sel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
